ram_stream_reader: RTL and testbench
====================================

// Module: ram_stream_reader
// PURPOSE
//  Read-side master for simple_dual_port_ram, with the RAM built for 1-cycle output latency.
//  On a start command it reads `length` consecutive words from `start_addr`.
//  It streams them out as AXI4-Stream with tlast on the final word, and full backpressure support.
//  It sits between a RAM filled by a writer (DMA/capture) and a downstream stream consumer.
// PARAMETERS
//  DATA_WIDTH  8   RAM word width and m_axis_tdata width
//  ADDR_WIDTH  8   RAM address width; max transfer = 2**ADDR_WIDTH words
// PORTS
//  clk                 in   1             single clock for all logic
//  rst_n               in   1             asynchronous active-low reset
//  start               in   1             1-cycle command strobe, accepted only when busy=0
//  start_addr          in   ADDR_WIDTH    first word address
//  length              in   ADDR_WIDTH+1  words to read, 0..2**ADDR_WIDTH
//  busy                out  1             transfer in progress
//  done                out  1             1-cycle pulse, transfer complete
//  ram_rd_en           out  1             RAM read enable
//  ram_rd_addr         out  ADDR_WIDTH    RAM read address
//  ram_rd_data         in   DATA_WIDTH    RAM read data, 1 cycle after ram_rd_en
//  ram_rd_data_valid   in   1             RAM read-data valid
//  m_axis_tdata        out  DATA_WIDTH    stream data
//  m_axis_tvalid       out  1             stream valid
//  m_axis_tready       in   1             stream ready
//  m_axis_tlast        out  1             high with the last word of the transfer
// BEHAVIOUR
//  - Reset values: all outputs 0. The FSM goes to IDLE; counters and the skid FIFO are cleared.
//  - FSM IDLE -> READ: on start with length!=0. Latch addr and length; busy=1 from the next cycle.
//  - IDLE with start and length==0: no reads, no beats; done pulses next cycle, busy stays 0.
//  - start while busy=1: ignored, no effect on the running transfer.
//  - READ: issue ram_rd_en=1 with ram_rd_addr=addr when credit is available.
//    Per issue: addr+1 (wraps modulo 2**ADDR_WIDTH), remaining-1.
//    READ -> DRAIN in the cycle the last read is issued.
//  - Credit rule: issue iff (fifo_count + inflight) < 2 OR (m_axis_tvalid && m_axis_tready).
//    inflight is a 1-bit counter of issued-but-unreturned reads.
//  - Return path: push ram_rd_data into the 2-entry skid FIFO only when ram_rd_data_valid=1 and inflight=1.
//    Valid with no inflight read: discarded (covers stale data after reset).
//  - The FIFO never overflows. Simultaneous push and pop keeps the count unchanged.
//  - Output: m_axis_tvalid = FIFO non-empty; tdata = FIFO head.
//    tdata and tlast hold stable while tvalid=1 and tready=0.
//  - tlast: set on the word tagged as last at issue time; the tag is carried through the FIFO.
//  - Throughput: 1 word/clk with tready held high.
//    Latency start -> first tvalid is 3 clk (latch, issue, RAM return).
//  - DRAIN -> IDLE: on the handshake of the tlast word. done=1 the next cycle, same cycle busy -> 0.
//  - A new start is accepted in the cycle done=1.
//  - Async reset mid-transfer: the transfer is aborted, no done pulse, and FIFO contents are lost.
//    A RAM return arriving after reset release is ignored by the inflight rule.
// STRUCTURE
//  - ram_reader_pkg: typedef enum logic [1:0] {IDLE, READ, DRAIN} ram_reader_state_t.
//    The package also holds localparam SKID_DEPTH = 2.
//  - Sub-module stream_skid_fifo: 2-entry FIFO of {last, data} with push, pop, count, full and empty.
//    Async active-low reset.
//  - The top level holds the FSM, address/remaining counters, the inflight bit and the credit logic.
// TESTING (DUT wired to simple_dual_port_ram, DW=8, AW=4, IS_OUT_LATENCY="true", preloaded mem[i]=i)
//  1. start addr=2 len=5, tready=1.
//     -> beats 02,03,04,05,06 on consecutive clks; tlast on 06; done 1 clk later.
//  2. start addr=14 len=4.
//     -> beats 0E,0F,00,01 (wrap); tlast on 01.
//  3. len=6, tready toggled by a random 50% pattern.
//     -> in-order 6 beats, none lost or duplicated; tdata stable while stalled.
//     -> ram_rd_en never issues with count+inflight=2 and no pop.
//  4. start len=0.
//     -> done pulses next clk; no ram_rd_en; tvalid stays 0.
//  5. Second start during busy (different addr).
//     -> ignored; original transfer completes intact; new start accepted on the done cycle.
//  6. rst_n low for 1 clk mid-transfer after 2 beats.
//     -> outputs 0 immediately; no done pulse.
//     -> the next start len=3 addr=0 yields 00,01,02 cleanly.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader: FSM states, skid FIFO
// sizing and the read-credit rule.
package ram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } ram_reader_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    typedef logic [SKID_CNT_W-1:0] skid_count_t;

    localparam skid_count_t             SKID_CNT_ONE  = skid_count_t'(1);
    localparam skid_count_t             SKID_CNT_FULL = skid_count_t'(SKID_DEPTH);
    localparam logic [SKID_CNT_W:0]     SKID_LIMIT    = (SKID_CNT_W + 1)'(SKID_DEPTH);

    // A read may go out only if its word is guaranteed a FIFO slot on return.
    function automatic logic read_credit(input skid_count_t fifo_count,
                                         input logic        inflight,
                                         input logic        popping);
        logic [SKID_CNT_W:0] outstanding;
        outstanding = {1'b0, fifo_count} + {{SKID_CNT_W{1'b0}}, inflight};
        return (outstanding < SKID_LIMIT) || popping;
    endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// AXI4-Stream bundle produced by the RAM stream reader.
interface ram_stream_reader_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/ram_stream_reader_skid_fifo.sv
// Two-entry FIFO holding {last, data} words returned by the RAM until the
// stream consumer takes them.
module stream_skid_fifo
    import ram_reader_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output skid_count_t      count,
    output logic             full,
    output logic             empty
);

    localparam int                PTR_W   = $clog2(SKID_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] mem_r [SKID_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    skid_count_t      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests so an empty pop or a full push without pop is dropped.
    always_comb begin
        pop_ok_s  = pop && (count_r != '0);
        push_ok_s = push && ((count_r != SKID_CNT_FULL) || pop_ok_s);
    end

    // Storage and write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
        end
    end

    // Read pointer and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + SKID_CNT_ONE;
                2'b01:   count_r <= count_r - SKID_CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == SKID_CNT_FULL);
    assign empty = (count_r == '0);

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a block of consecutive RAM words (1-cycle read latency) and streams
// them out as AXI4-Stream with tlast on the final word.
module ram_stream_reader
    import ram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    input  logic                  ram_rd_data_valid,
    ram_stream_reader_if.master   axis
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);

    ram_reader_state_t     state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH:0]   remaining_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  inflight_r;
    logic                  inflight_last_r;

    logic                  issue_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  last_tag_s;
    logic [DATA_WIDTH:0]   fifo_head_s;
    skid_count_t           fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    // Handshake, return acceptance and read-issue decisions for this cycle.
    always_comb begin
        pop_s      = !fifo_empty_s && axis.m_axis_tready;
        push_s     = ram_rd_data_valid && inflight_r && (!fifo_full_s || pop_s);
        last_tag_s = (remaining_r == LEN_ONE);
        if (state_r == READ) begin
            issue_s = read_credit(fifo_count_s, inflight_r, pop_s);
        end else begin
            issue_s = 1'b0;
        end
    end

    // Transfer FSM with address/remaining counters and registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            addr_r      <= '0;
            remaining_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            addr_r      <= start_addr;
                            remaining_r <= length;
                            busy_r      <= 1'b1;
                            state_r     <= READ;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue_s) begin
                        addr_r      <= addr_r + ADDR_ONE;
                        remaining_r <= remaining_r - LEN_ONE;
                        if (last_tag_s) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The transfer ends only when the consumer takes the tlast word.
                    if (pop_s && fifo_head_s[DATA_WIDTH]) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding-read bit and the last tag that travels with it; a return
    // with no read outstanding (stale after reset) is never pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else if (issue_s) begin
            inflight_r      <= 1'b1;
            inflight_last_r <= last_tag_s;
        end else if (push_s) begin
            inflight_r      <= 1'b0;
        end
    end

    stream_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data ({inflight_last_r, ram_rd_data}),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign busy               = busy_r;
    assign done               = done_r;
    assign ram_rd_en          = issue_s;
    assign ram_rd_addr        = addr_r;
    assign axis.m_axis_tvalid = !fifo_empty_s;
    assign axis.m_axis_tdata  = fifo_head_s[DATA_WIDTH-1:0];
    assign axis.m_axis_tlast  = fifo_head_s[DATA_WIDTH] && !fifo_empty_s;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader with a 1-cycle-latency RAM model
// preloaded with mem[i] = i.
module tb_ram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data = '0;
    logic          ram_rd_data_valid = 1'b0;

    ram_stream_reader_if #(.DATA_WIDTH(DW)) axis_if ();

    ram_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .start_addr        (start_addr),
        .length            (length),
        .busy              (busy),
        .done              (done),
        .ram_rd_en         (ram_rd_en),
        .ram_rd_addr       (ram_rd_addr),
        .ram_rd_data       (ram_rd_data),
        .ram_rd_data_valid (ram_rd_data_valid),
        .axis              (axis_if.master)
    );

    always #5 clk = ~clk;

    // RAM with registered output; not reset, so a read in flight survives a DUT reset.
    always @(posedge clk) begin
        ram_rd_data_valid <= ram_rd_en;
        if (ram_rd_en) ram_rd_data <= DW'(ram_rd_addr);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected read addresses and expected {last,data} beats.
    logic [AW-1:0] rd_exp_q[$];
    logic [DW:0]   exp_q[$];
    int issued = 0, popped = 0, done_cnt = 0;
    int beat_idx = 0, first_cyc = -1, last_cyc = -1, done_cyc = -1;
    logic [DW-1:0] first_data = '0, last_data = '0;
    int ready_mode = 0;

    task automatic model_push(input int addr, input int len);
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a;
            a = AW'((addr + i) % DEPTH);
            rd_exp_q.push_back(a);
            exp_q.push_back({(i == len - 1), DW'(a)});
        end
    endtask

    task automatic model_clear();
        rd_exp_q.delete();
        exp_q.delete();
        issued = 0;
        popped = 0;
    endtask

    // Consumer ready: always high, or a random 50% pattern.
    initial begin
        axis_if.m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            axis_if.m_axis_tready = (ready_mode != 0) ? 1'($urandom % 2) : 1'b1;
        end
    end

    // Monitor on the falling edge: reads, credit, beats, stability, done.
    logic          prev_stall = 1'b0;
    logic [DW:0]   prev_word = '0;
    logic          mon_pop;
    int            outst;
    logic [DW:0]   e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            mon_pop = axis_if.m_axis_tvalid && axis_if.m_axis_tready;
            outst   = issued - popped;
            if (busy && rd_exp_q.size() > 0)
                chk("issue_credit", ram_rd_en, (outst < 2) || mon_pop);
            else
                chk("spurious_read", ram_rd_en, 0);
            if (ram_rd_en) begin
                if (rd_exp_q.size() > 0) chk("rd_addr", ram_rd_addr, rd_exp_q.pop_front());
                issued++;
            end
            if (prev_stall) begin
                chk("stall_tvalid", axis_if.m_axis_tvalid, 1);
                chk("stall_hold", {axis_if.m_axis_tlast, axis_if.m_axis_tdata}, prev_word);
            end
            if (axis_if.m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", axis_if.m_axis_tvalid, 0);
                end else if (mon_pop) begin
                    e = exp_q.pop_front();
                    chk("beat_data", axis_if.m_axis_tdata, e[DW-1:0]);
                    chk("beat_last", axis_if.m_axis_tlast, e[DW]);
                    if (beat_idx == 0) begin
                        first_data = axis_if.m_axis_tdata;
                        first_cyc  = cyc;
                    end
                    if (axis_if.m_axis_tlast) begin
                        last_data = axis_if.m_axis_tdata;
                        last_cyc  = cyc;
                    end
                    beat_idx++;
                    popped++;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = axis_if.m_axis_tvalid && !axis_if.m_axis_tready;
            prev_word  = {axis_if.m_axis_tlast, axis_if.m_axis_tdata};
        end
    end

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_done"}, done_cnt, target);
    endtask

    task automatic run_xfer(input int addr, input int len, input int rdy,
                            input int e_first, input int e_last, input int e_beats,
                            input string tag);
        int n;
        int target;
        ready_mode = rdy;
        beat_idx = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        model_push(addr, len);
        target = done_cnt + 1;
        start = 1'b1; start_addr = AW'(addr); length = (AW + 1)'(len);
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        n = 1;
        while (!axis_if.m_axis_tvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 3);
        wait_done(target, tag);
        chk({tag, "_beats"}, beat_idx, e_beats);
        chk({tag, "_first"}, first_data, e_first);
        chk({tag, "_last"}, last_data, e_last);
        chk({tag, "_done_gap"}, done_cyc - last_cyc, 1);
        if (rdy == 0) chk({tag, "_span"}, last_cyc - first_cyc, len - 1);
        chk({tag, "_leftover"}, exp_q.size() + rd_exp_q.size(), 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    typedef struct {
        int addr;
        int len;
        int rdy;
        int exp_first;
        int exp_last;
        int exp_beats;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int target;
        int n;
        int a, l, r;

        vecs[0] = '{2,  5, 0, 'h02, 'h06, 5};
        vecs[1] = '{14, 4, 0, 'h0E, 'h01, 4};
        vecs[2] = '{7,  6, 1, 'h07, 'h0C, 6};
        vecs[3] = '{0, 16, 0, 'h00, 'h0F, 16};
        vecs[4] = '{15, 1, 1, 'h0F, 'h0F, 1};
        vecs[5] = '{9, 16, 1, 'h09, 'h08, 16};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, ram_rd_en, ram_rd_addr, axis_if.m_axis_tvalid,
                              axis_if.m_axis_tlast, axis_if.m_axis_tdata}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_xfer(vecs[i].addr, vecs[i].len, vecs[i].rdy, vecs[i].exp_first,
                     vecs[i].exp_last, vecs[i].exp_beats, $sformatf("vec%0d", i));

        // Zero-length start: done next clock, no reads, no beats.
        ready_mode = 0;
        target = done_cnt + 1;
        start = 1'b1; start_addr = AW'(5); length = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("len0_tvalid", axis_if.m_axis_tvalid, 0);
        end
        chk("len0_pulses", done_cnt, target);

        // Start while busy is ignored; a new start is taken in the done cycle.
        beat_idx = 0;
        model_push(1, 6);
        target = done_cnt + 1;
        start = 1'b1; start_addr = AW'(1); length = (AW + 1)'(6);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = AW'(9); length = (AW + 1)'(3);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_start_done", done, 1);
        chk("busy_start_beats", beat_idx, 6);
        chk("busy_start_last", last_data, 'h06);
        beat_idx = 0;
        model_push(9, 3);
        start = 1'b1; start_addr = AW'(9); length = (AW + 1)'(3);
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_cycle_accept", busy, 1);
        wait_done(target + 1, "done_cycle");
        chk("done_cycle_first", first_data, 'h09);
        chk("done_cycle_last", last_data, 'h0B);
        chk("done_cycle_leftover", exp_q.size() + rd_exp_q.size(), 0);

        // Reset mid-transfer after two beats; the pending RAM return must be dropped.
        beat_idx = 0;
        model_push(3, 12);
        start = 1'b1; start_addr = AW'(3); length = (AW + 1)'(12);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (beat_idx < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_pre_beats", beat_idx, 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_outputs", {busy, done, ram_rd_en, ram_rd_addr, axis_if.m_axis_tvalid,
                            axis_if.m_axis_tlast, axis_if.m_axis_tdata}, 0);
        target = done_cnt;
        #6;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("rst_stale_tvalid", axis_if.m_axis_tvalid, 0);
        end
        chk("rst_no_done", done_cnt, target);
        chk("rst_idle", busy, 0);
        run_xfer(0, 3, 0, 'h00, 'h02, 3, "post_rst");

        // Randomized transfers against the model.
        for (int k = 0; k < 20; k++) begin
            a = int'($urandom % DEPTH);
            l = int'($urandom_range(1, DEPTH));
            r = int'($urandom % 2);
            run_xfer(a, l, r, a, (a + l - 1) % DEPTH, l, $sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
